bcd2hgfe_tx: RTL and testbench



---
 rtl/hgfe_pkg.sv | 24 ++
 rtl/bcd2hgfe_enc.sv | 20 ++
 rtl/bcd2hgfe_tx.sv | 111 +++++++++++
 tb/tb_bcd2hgfe_tx.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/hgfe_pkg.sv
// Shared definitions for the hgfe digit link.
// Covers the line code table, framing constants and tx states.
package hgfe_pkg;

   localparam int FRAME_BITS = 6;
   localparam int DATA_BITS  = 4;

   localparam logic [3:0] CODE_TABLE [10] = '{
      4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0101,
      4'b0111, 4'b1001, 4'b1011, 4'b1100, 4'b1101
   };

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_e;

   function automatic logic is_legal(input logic [3:0] d);
      return d <= 4'd9;
   endfunction

endpackage

// File: rtl/bcd2hgfe_enc.sv
// BCD digit to hgfe code, purely combinational.
// Illegal digits give code 0000 with legal_o low.
module bcd2hgfe_enc
   import hgfe_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [3:0] code_o,
   output logic       legal_o
);

   always_comb begin
      code_o = '0;
      for (int i = 0; i < 10; i++) begin
         if (digit_i == 4'(i)) code_o = CODE_TABLE[i];
      end
   end

   assign legal_o = is_legal(digit_i);

endmodule

// File: rtl/bcd2hgfe_tx.sv
// hgfe link transmitter: framed serial word plus parallel code.
// Frame is start, h, g, f, e, stop; each bit lasts BIT_CYCLES clocks.
module bcd2hgfe_tx
   import hgfe_pkg::*;
#(
   parameter int BIT_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_digit,
   output logic       ser_out,
   output logic       busy,
   output logic [3:0] code_out,
   output logic       err
);

   logic [3:0] enc_code;
   logic       enc_legal;

   tx_state_e  state_q, state_d;
   logic [1:0] bit_q, bit_d;
   logic [7:0] cyc_q, cyc_d;
   logic [3:0] shift_q, shift_d;
   logic [3:0] code_q, code_d;
   logic       err_q, err_d;
   logic       accept;
   logic       bit_end;

   bcd2hgfe_enc u_enc (
      .digit_i (in_digit),
      .code_o  (enc_code),
      .legal_o (enc_legal)
   );

   assign accept  = in_valid && (state_q == IDLE);
   assign bit_end = (cyc_q == 8'(BIT_CYCLES - 1));

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      cyc_d   = cyc_q;
      shift_d = shift_q;
      code_d  = code_q;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept && enc_legal) begin
               state_d = START;
               shift_d = enc_code;
               code_d  = enc_code;
               cyc_d   = '0;
               bit_d   = '0;
            end else if (accept) begin
               err_d = 1'b1;
            end
         end
         START: begin
            cyc_d = bit_end ? '0 : cyc_q + 8'd1;
            if (bit_end) state_d = DATA;
         end
         DATA: begin
            cyc_d = bit_end ? '0 : cyc_q + 8'd1;
            if (bit_end) begin
               shift_d = {shift_q[2:0], 1'b0};
               bit_d   = bit_q + 2'd1;
               if (bit_q == 2'(DATA_BITS - 1)) state_d = STOP;
            end
         end
         STOP: begin
            cyc_d = bit_end ? '0 : cyc_q + 8'd1;
            if (bit_end) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         bit_q   <= '0;
         cyc_q   <= '0;
         shift_q <= '0;
         code_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         cyc_q   <= cyc_d;
         shift_q <= shift_d;
         code_q  <= code_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      ser_out = 1'b1;
      unique case (state_q)
         START:   ser_out = 1'b0;
         DATA:    ser_out = shift_q[3];
         default: ser_out = 1'b1;
      endcase
   end

   assign in_ready = (state_q == IDLE);
   assign busy     = (state_q != IDLE);
   assign code_out = code_q;
   assign err      = err_q;

endmodule

// File: tb/tb_bcd2hgfe_tx.sv
// Directed scoreboard bench for bcd2hgfe_tx.
// Three instances run with BIT_CYCLES of 1, 2 and 3.
module tb_bcd2hgfe_tx;
   import hgfe_pkg::*;

   localparam logic [3:0] TB_TBL [10] = '{
      4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0101,
      4'b0111, 4'b1001, 4'b1011, 4'b1100, 4'b1101
   };

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       rst_n    [3];
   logic       in_valid [3];
   logic [3:0] in_digit [3];
   logic       in_ready [3];
   logic       ser_out  [3];
   logic       busy     [3];
   logic [3:0] code_out [3];
   logic       err      [3];

   logic       exp_q [$];
   int         dig_q [$];
   logic [3:0] exp_code [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      bcd2hgfe_tx #(.BIT_CYCLES(g + 1)) u_dut (
         .clk      (clk),
         .rst_n    (rst_n[g]),
         .in_valid (in_valid[g]),
         .in_ready (in_ready[g]),
         .in_digit (in_digit[g]),
         .ser_out  (ser_out[g]),
         .busy     (busy[g]),
         .code_out (code_out[g]),
         .err      (err[g])
      );
   end

   task automatic check(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input int idx, input string tag);
      check({tag, "_ser"}, 8'(ser_out[idx]), 8'd1);
      check({tag, "_busy"}, 8'(busy[idx]), 8'd0);
      check({tag, "_ready"}, 8'(in_ready[idx]), 8'd1);
      check({tag, "_code"}, 8'(code_out[idx]), 8'(exp_code[idx]));
   endtask

   // Called just after a negedge; returns just after a negedge.
   task automatic send(input int idx, input logic [3:0] d, output int acc);
      int b;
      logic [3:0] c;
      logic [3:0] rx;
      int got;
      b = idx + 1;
      rx = '0;
      got = 15;
      check("ready_before", 8'(in_ready[idx]), 8'd1);
      in_valid[idx] = 1'b1;
      in_digit[idx] = d;
      @(posedge clk);
      acc = cyc;
      if (d <= 4'd9) begin
         c = TB_TBL[d];
         repeat (b) exp_q.push_back(1'b0);
         for (int i = 3; i >= 0; i--) repeat (b) exp_q.push_back(c[i]);
         repeat (b) exp_q.push_back(1'b1);
         dig_q.push_back(int'(d));
         exp_code[idx] = c;
      end
      @(negedge clk);
      in_valid[idx] = 1'b0;
      if (d > 4'd9) begin
         check("err_pulse", 8'(err[idx]), 8'd1);
         check_idle(idx, "illegal");
         return;
      end
      for (int n = 0; n < FRAME_BITS * b; n++) begin
         if (n > 0) @(negedge clk);
         check("ser", 8'(ser_out[idx]), 8'(exp_q.pop_front()));
         check("busy", 8'(busy[idx]), 8'd1);
         if (n == 0) begin
            check("code", 8'(code_out[idx]), 8'(exp_code[idx]));
            check("err_low", 8'(err[idx]), 8'd0);
            check("ready_low", 8'(in_ready[idx]), 8'd0);
         end
         if (n >= b && n < 5 * b && (n % b) == 0)
            rx = {rx[2:0], ser_out[idx]};
      end
      for (int j = 0; j < 10; j++) if (TB_TBL[j] == rx) got = j;
      check("rx_digit", 8'(got), 8'(dig_q.pop_front()));
      @(negedge clk);
      check_idle(idx, "post");
   endtask

   initial begin
      int a;
      int b2;
      for (int i = 0; i < 3; i++) begin
         rst_n[i] = 1'b0;
         in_valid[i] = 1'b0;
         in_digit[i] = '0;
         exp_code[i] = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check_idle(0, "idle");
         check("idle_err", 8'(err[0]), 8'd0);
      end

      send(0, 4'd7, a);

      send(2, 4'd9, a);
      send(2, 4'd2, b2);
      check("spacing", 8'(b2 - a), 8'd19);

      send(0, 4'd12, a);
      send(0, 4'd4, b2);
      check("illegal_then_accept", 8'(b2 - a), 8'd1);

      for (int d = 0; d < 10; d++) send(0, 4'(d), a);

      // Abort digit 5 during its g bit on the B=2 instance.
      in_valid[1] = 1'b1;
      in_digit[1] = 4'd5;
      @(posedge clk);
      @(negedge clk);
      in_valid[1] = 1'b0;
      check("abort_start", 8'(ser_out[1]), 8'd0);
      repeat (4) @(negedge clk);
      check("abort_gbit", 8'(ser_out[1]), 8'd1);
      check("abort_busy", 8'(busy[1]), 8'd1);
      rst_n[1] = 1'b0;
      @(negedge clk);
      rst_n[1] = 1'b1;
      exp_code[1] = '0;
      check_idle(1, "abort");
      send(1, 4'd3, a);

      // Reset and valid together: the digit must be dropped.
      rst_n[2] = 1'b0;
      in_valid[2] = 1'b1;
      in_digit[2] = 4'd8;
      @(negedge clk);
      in_valid[2] = 1'b0;
      rst_n[2] = 1'b1;
      exp_code[2] = '0;
      check_idle(2, "rstvalid");
      @(negedge clk);
      check_idle(2, "rstvalid2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
